pulse_interval_monitor: RTL and testbench
=========================================

# pulse_interval_monitor

Receive-side companion to the random pulse generator. Samples the single-bit pulse stream and measures the interval between consecutive rising edges and the high width of each pulse. Keeps a saturating pulse count plus last, minimum and maximum interval statistics, and exposes them over a byte-wide register mux. Sits next to the generator in the same tile and is driven from its pulse output, or from an external pin via the optional synchronizer.

## Interface
- CNT_W, 16: width of the count, interval and width registers; legal range 8..16; readout zero-extends to 16 bits.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  measurement enable; low freezes all counters and statistics.
- pulse_in  in  1  pulse stream under measurement.
- clear  in  1  synchronous statistics clear, single-cycle or level.
- sel  in  4  readout register select.
- data_out  out  8  selected register byte, registered.
- interval_valid  out  1  one-cycle strobe: new interval captured.
- overflow  out  1  sticky: an interval or width counter saturated.
- pulse_seen  out  1  at least one rising edge since reset/clear.

## Operation
- Edge detect: p_d <= p_s each cycle, regardless of ena/clear. rise = p_s & ~p_d; fall = ~p_s & p_d. p_s is pulse_in, or its synchronized copy (see Configuration).
- FSM states: IDLE (no edge yet), FIRST (one edge seen, no interval yet), RUN (at least one interval captured).
  - IDLE -> FIRST on rise.
  - FIRST -> RUN on rise.
  - RUN stays in RUN on rise.
  - Any state -> IDLE on rst or clear.
- Gap counter:
  - Loaded with 1 in the cycle after a rise; increments by 1 each enabled cycle.
  - Saturates at 2^CNT_W-1 and sets overflow.
  - On a rise in FIRST or RUN: last_interval <= gap count, i.e. the cycle distance between edges. Edges at cycles t and t+k give interval k.
  - min_interval <= min(min, k); max_interval <= max(max, k); interval_valid pulses next cycle.
- Width counter:
  - Loaded with 1 on rise; increments while p_s is high; saturates and sets overflow.
  - On fall: last_width <= counter.
  - A single-cycle pulse gives width 1.
- pulse_count increments on each rise and saturates at 2^CNT_W-1. Saturation of pulse_count does not set overflow.
- Reset and clear values:
  - state IDLE; count, last_interval, max_interval, last_width = 0; min_interval = all ones.
  - overflow = 0; pulse_seen = 0; interval_valid = 0; data_out = 0.
- Readout (sel): 0/1 count lo/hi; 2/3 last_interval lo/hi; 4/5 min lo/hi; 6/7 max lo/hi; 8/9 last_width lo/hi; 10 status {4'b0, overflow, pulse_seen, state[1:0]} with IDLE=0, FIRST=1, RUN=2; 11-15 read 0x00.
- Boundary rules:
  - ena low: rises and falls are ignored and nothing updates except the edge history, so re-enabling never produces a spurious edge.
  - A rise in the same cycle as clear is discarded; clear wins.
  - rst wins over everything.
  - min/max reads all-ones/0 until the first interval is captured.
  - rise and fall cannot coincide.

## Timing
- Stat registers update at the clock edge that ends the rise or fall cycle.
- interval_valid is high for exactly one cycle, the cycle after capture.
- data_out latency is one cycle from sel, reflecting register contents as of the previous edge. Reading never disturbs state.
- Input-to-detect latency: 0 cycles from p_s; with the synchronizer, 2 extra cycles.
- Minimum measurable interval is 2: a pulse must be high 1 cycle and low 1 cycle.

## Configuration
- PULSE_SYNC_EN defined: pulse_in passes through a 2-flop synchronizer reset to 0. Use this when the source is an external pin.
- PULSE_SYNC_EN undefined: p_s = pulse_in directly. The input must come from the clk domain.
- All measured values are identical in both builds; only the absolute detection time shifts by 2 cycles.

## Test plan
- Reset / clear values: hold rst 2 cycles, then read sel 0..10. Expect 00 for all except min (sel 4,5 = FF,FF) and status = 0x00.
- Intervals: rises at intervals 5 then 9, each pulse 2 cycles wide, no synchronizer.
  - Expect last_interval=9, min=5, max=9, count=3, last_width=2, status=0x06.
  - Expect interval_valid high exactly 2 single cycles.
- Saturation: CNT_W=8, gap of 300 cycles.
  - Expect last_interval=255 and overflow=1.
  - overflow stays set through later normal intervals until clear.
- Clear collision: assert clear in the same cycle as a rise mid-stream.
  - Expect state IDLE and count 0 afterwards.
  - The next rise gives count 1 and state FIRST.
- ena gating: pulse_in held high across an ena-low window, ena re-asserted while still high. Expect no count increment; width counting resumes only at the next real rise.
- PULSE_SYNC_EN build: repeat the interval scenario. Expect identical values, with interval_valid delayed 2 cycles.

Source files
------------

// File: rtl/pulse_interval_monitor.sv
// Purpose  : measures rising-edge intervals and high widths of a 1-bit pulse stream,
//            keeping count / last / min / max statistics behind a byte-wide readout mux.
// Latency  : edge detect 0 cycles from p_s (2 more with PULSE_SYNC_EN); stats update at
//            the edge ending the rise/fall cycle; data_out is one cycle behind sel.
// Backpressure: none; the input is sampled every cycle and i_ena freezes measurement.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_ena               measurement enable (low freezes everything but edge history)
//   i_pulse_in          pulse stream under measurement
//   i_clear             synchronous statistics clear
//   i_sel[3:0]          readout select (0..9 stat bytes lo/hi, 10 status, 11..15 zero)
//   o_data_out[7:0]     registered readout byte
//   o_interval_valid    one-cycle strobe after each interval capture
//   o_overflow          sticky: gap or width counter saturated
//   o_pulse_seen        a rising edge was seen since reset/clear
// Build option: define PULSE_SYNC_EN to put a 2-flop synchronizer on i_pulse_in.
module pulse_interval_monitor #(
  parameter int CNT_W = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ena,
  input  logic       i_pulse_in,
  input  logic       i_clear,
  input  logic [3:0] i_sel,
  output logic [7:0] o_data_out,
  output logic       o_interval_valid,
  output logic       o_overflow,
  output logic       o_pulse_seen
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_MAX = '1;
  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             w_p_s;
  logic             r_p_d;
  logic             w_rise;
  logic             w_fall;
  logic             w_capture;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_gap;
  logic [CNT_W-1:0] r_last_int;
  logic [CNT_W-1:0] r_min_int;
  logic [CNT_W-1:0] r_max_int;
  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] r_last_w;
  logic             r_w_act;
  logic             r_ovf;
  logic             r_ival;
  logic [7:0]       r_data;
  logic [7:0]       w_byte;
  logic [15:0]      w_cnt_x;
  logic [15:0]      w_last_x;
  logic [15:0]      w_min_x;
  logic [15:0]      w_max_x;
  logic [15:0]      w_lw_x;

`ifdef PULSE_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[0], i_pulse_in};
  end

  assign w_p_s = r_sync[1];
`else
  assign w_p_s = i_pulse_in;
`endif

  // Edge history tracks p_s even while disabled or clearing, so re-enabling
  // with the input already high never looks like a fresh rise.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_p_d <= 1'b0;
    else       r_p_d <= w_p_s;
  end

  // A rise coinciding with clear is dropped: clear wins.
  assign w_rise    = w_p_s & ~r_p_d & i_ena & ~i_clear;
  assign w_fall    = ~w_p_s & r_p_d & i_ena & ~i_clear;
  assign w_capture = w_rise & (r_state != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_clear) begin
      w_state_nxt = S_IDLE;
    end else if (w_rise) begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_FIRST;
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt      <= '0;
      r_gap      <= '0;
      r_last_int <= '0;
      r_min_int  <= C_MAX;
      r_max_int  <= '0;
      r_width    <= '0;
      r_last_w   <= '0;
      r_w_act    <= 1'b0;
      r_ovf      <= 1'b0;
      r_ival     <= 1'b0;
      r_data     <= '0;
    end else begin
      r_ival <= w_capture;
      r_data <= w_byte;
      if (w_rise) begin
        if (r_cnt != C_MAX) r_cnt <= r_cnt + C_ONE;
        // Both counters include the rise cycle itself, so edges k cycles
        // apart read k and a one-cycle pulse reads width 1.
        r_gap   <= C_ONE;
        r_width <= C_ONE;
        r_w_act <= 1'b1;
        if (w_capture) begin
          r_last_int <= r_gap;
          if (r_gap < r_min_int) r_min_int <= r_gap;
          if (r_gap > r_max_int) r_max_int <= r_gap;
        end
      end else if (i_ena) begin
        // The gap only means something once an edge has been seen.
        if (r_state != S_IDLE) begin
          if (r_gap != C_MAX) r_gap <= r_gap + C_ONE;
          else                r_ovf <= 1'b1;
        end
        if (w_fall) begin
          // A fall without a measured rise (e.g. input went high while disabled)
          // has no valid width.
          if (r_w_act) r_last_w <= r_width;
          r_w_act <= 1'b0;
        end else if (r_w_act && w_p_s) begin
          if (r_width != C_MAX) r_width <= r_width + C_ONE;
          else                  r_ovf   <= 1'b1;
        end
      end
    end
  end

  assign w_cnt_x  = 16'(r_cnt);
  assign w_last_x = 16'(r_last_int);
  assign w_min_x  = 16'(r_min_int);
  assign w_max_x  = 16'(r_max_int);
  assign w_lw_x   = 16'(r_last_w);

  always_comb begin
    w_byte = 8'h00;
    case (i_sel)
      4'd0:    w_byte = w_cnt_x[7:0];
      4'd1:    w_byte = w_cnt_x[15:8];
      4'd2:    w_byte = w_last_x[7:0];
      4'd3:    w_byte = w_last_x[15:8];
      4'd4:    w_byte = w_min_x[7:0];
      4'd5:    w_byte = w_min_x[15:8];
      4'd6:    w_byte = w_max_x[7:0];
      4'd7:    w_byte = w_max_x[15:8];
      4'd8:    w_byte = w_lw_x[7:0];
      4'd9:    w_byte = w_lw_x[15:8];
      4'd10:   w_byte = {4'b0000, r_ovf, (r_state != S_IDLE), r_state};
      default: w_byte = 8'h00;
    endcase
  end

  assign o_data_out       = r_data;
  assign o_interval_valid = r_ival;
  assign o_overflow       = r_ovf;
  assign o_pulse_seen     = (r_state != S_IDLE);

endmodule

// File: tb/tb_pulse_interval_monitor.sv
// Directed bench for pulse_interval_monitor: a CNT_W=16 and a CNT_W=8 instance share
// the same stimulus; expected values are hand-computed per scenario.
// Works in both builds; LAT is the extra detection delay of the synchronizer.
module tb_pulse_interval_monitor;

`ifdef PULSE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  // sel 0..10 after reset/clear (16-bit and 8-bit instances)
  localparam logic [7:0] EXP_RST16 [11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF,
                                            8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  localparam logic [7:0] EXP_RST8  [11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00,
                                            8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  // intervals 5 then 9, width 2, three pulses: identical in both widths
  localparam logic [7:0] EXP_INT   [11] = '{8'h03, 8'h00, 8'h09, 8'h00, 8'h05, 8'h00,
                                            8'h09, 8'h00, 8'h02, 8'h00, 8'h06};

  logic       clk;
  logic       rst;
  logic       ena;
  logic       pulse;
  logic       clear;
  logic [3:0] sel;
  logic [7:0] dout16, dout8;
  logic       iv16, iv8, ov16, ov8, ps16, ps8;

  int         n_cmp;
  int         n_err;
  int         cyc;
  int         iv_cnt;
  int         iv_cyc [2];
  logic [7:0] rd16, rd8;

  pulse_interval_monitor #(.CNT_W(16)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_pulse_in(pulse), .i_clear(clear),
    .i_sel(sel), .o_data_out(dout16), .o_interval_valid(iv16),
    .o_overflow(ov16), .o_pulse_seen(ps16)
  );

  pulse_interval_monitor #(.CNT_W(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_pulse_in(pulse), .i_clear(clear),
    .i_sel(sel), .o_data_out(dout8), .o_interval_valid(iv8),
    .o_overflow(ov8), .o_pulse_seen(ps8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
    if (iv16) begin
      if (iv_cnt < 2) iv_cyc[iv_cnt] = cyc;
      iv_cnt++;
    end
  endtask

  task automatic rd(input logic [3:0] s);
    sel = s;
    tick();
    rd16 = dout16;
    rd8  = dout8;
  endtask

  task automatic hold(input logic v, input int n);
    pulse = v;
    repeat (n) tick();
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; ena = 1'b1; pulse = 1'b0; clear = 1'b0; sel = 4'd0;
    tick(); tick();
    rst = 1'b0;
    n_cmp++;
    if ({dout16, iv16, ov16, ps16} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_outputs got dout=%02h iv=%0b ov=%0b ps=%0b exp all 0",
               dout16, iv16, ov16, ps16);
    end
    for (int i = 0; i < 11; i++) begin
      rd(4'(i));
      n_cmp++;
      if (rd16 !== EXP_RST16[i] || rd8 !== EXP_RST8[i]) begin
        n_err++;
        $display("FAIL reset_sel%0d got %02h/%02h exp %02h/%02h",
                 i, rd16, rd8, EXP_RST16[i], EXP_RST8[i]);
      end
    end
  endtask

  task automatic test_intervals;
    int s;
    do_clear();
    iv_cnt = 0;
    s = cyc;
    hold(1'b1, 2); hold(1'b0, 3);
    hold(1'b1, 2); hold(1'b0, 7);
    hold(1'b1, 2); hold(1'b0, 4);
    for (int i = 0; i < 11; i++) begin
      rd(4'(i));
      n_cmp++;
      if (rd16 !== EXP_INT[i] || rd8 !== EXP_INT[i]) begin
        n_err++;
        $display("FAIL intervals_sel%0d got %02h/%02h exp %02h", i, rd16, rd8, EXP_INT[i]);
      end
    end
    n_cmp++;
    if (iv_cnt !== 2) begin
      n_err++;
      $display("FAIL iv_strobe_count got %0d exp 2", iv_cnt);
    end
    n_cmp++;
    if (iv_cyc[0] !== s + 6 + LAT || iv_cyc[1] !== s + 15 + LAT) begin
      n_err++;
      $display("FAIL iv_strobe_cycles got %0d,%0d exp %0d,%0d",
               iv_cyc[0] - s, iv_cyc[1] - s, 6 + LAT, 15 + LAT);
    end
    for (int i = 11; i < 16; i++) begin
      rd(4'(i));
      n_cmp++;
      if (rd16 !== 8'h00) begin
        n_err++;
        $display("FAIL unused_sel%0d got %02h exp 00", i, rd16);
      end
    end
  endtask

  task automatic test_back_to_back;
    do_clear();
    hold(1'b1, 1); hold(1'b0, 1);
    hold(1'b1, 1); hold(1'b0, 1);
    hold(1'b1, 1); hold(1'b0, 4);
    rd(4'd0);
    n_cmp++;
    if (rd16 !== 8'h03) begin n_err++; $display("FAIL b2b_count got %02h exp 03", rd16); end
    rd(4'd2);
    n_cmp++;
    if (rd16 !== 8'h02) begin n_err++; $display("FAIL b2b_last got %02h exp 02", rd16); end
    rd(4'd4);
    n_cmp++;
    if (rd16 !== 8'h02) begin n_err++; $display("FAIL b2b_min got %02h exp 02", rd16); end
    rd(4'd6);
    n_cmp++;
    if (rd16 !== 8'h02) begin n_err++; $display("FAIL b2b_max got %02h exp 02", rd16); end
    rd(4'd8);
    n_cmp++;
    if (rd16 !== 8'h01) begin n_err++; $display("FAIL b2b_width got %02h exp 01", rd16); end
  endtask

  task automatic test_saturation;
    do_clear();
    hold(1'b1, 1); hold(1'b0, 299);
    hold(1'b1, 1); hold(1'b0, 3);
    rd(4'd2);
    n_cmp++;
    if (rd8 !== 8'hFF || rd16 !== 8'h2C) begin
      n_err++; $display("FAIL sat_last_lo got %02h/%02h exp FF/2C", rd8, rd16);
    end
    rd(4'd3);
    n_cmp++;
    if (rd8 !== 8'h00 || rd16 !== 8'h01) begin
      n_err++; $display("FAIL sat_last_hi got %02h/%02h exp 00/01", rd8, rd16);
    end
    rd(4'd10);
    n_cmp++;
    if (rd8 !== 8'h0E || rd16 !== 8'h06 || ov8 !== 1'b1) begin
      n_err++; $display("FAIL sat_status got %02h/%02h ov=%0b exp 0E/06 ov=1", rd8, rd16, ov8);
    end
    // A normal interval afterwards must leave overflow set.
    hold(1'b1, 1); hold(1'b0, 5);
    hold(1'b1, 1); hold(1'b0, 3);
    rd(4'd2);
    n_cmp++;
    if (rd8 !== 8'h06 || rd16 !== 8'h06) begin
      n_err++; $display("FAIL sat_next_last got %02h/%02h exp 06/06", rd8, rd16);
    end
    rd(4'd4);
    n_cmp++;
    if (rd8 !== 8'h06) begin n_err++; $display("FAIL sat_next_min got %02h exp 06", rd8); end
    rd(4'd10);
    n_cmp++;
    if (rd8 !== 8'h0E) begin n_err++; $display("FAIL sat_sticky got %02h exp 0E", rd8); end
    do_clear();
    rd(4'd10);
    n_cmp++;
    if (rd8 !== 8'h00 || ov8 !== 1'b0) begin
      n_err++; $display("FAIL sat_cleared got %02h ov=%0b exp 00 ov=0", rd8, ov8);
    end
  endtask

  task automatic test_clear_collision;
    do_clear();
    hold(1'b1, 2); hold(1'b0, 3);
    hold(1'b1, 2); hold(1'b0, 3);
    pulse = 1'b1;
    repeat (LAT) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    hold(1'b1, 1); hold(1'b0, 3);
    rd(4'd0);
    n_cmp++;
    if (rd16 !== 8'h00) begin n_err++; $display("FAIL coll_count got %02h exp 00", rd16); end
    rd(4'd10);
    n_cmp++;
    if (rd16 !== 8'h00) begin n_err++; $display("FAIL coll_status got %02h exp 00", rd16); end
    rd(4'd4);
    n_cmp++;
    if (rd16 !== 8'hFF) begin n_err++; $display("FAIL coll_min got %02h exp FF", rd16); end
    hold(1'b1, 1); hold(1'b0, 3);
    rd(4'd0);
    n_cmp++;
    if (rd16 !== 8'h01) begin n_err++; $display("FAIL coll_next_count got %02h exp 01", rd16); end
    rd(4'd10);
    n_cmp++;
    if (rd16 !== 8'h05) begin n_err++; $display("FAIL coll_next_status got %02h exp 05", rd16); end
  endtask

  task automatic test_ena_gating;
    do_clear();
    hold(1'b1, 2); hold(1'b0, 3);
    ena = 1'b0;
    hold(1'b1, 4);
    ena = 1'b1;
    hold(1'b1, 3);
    pulse = 1'b0;
    rd(4'd0);
    n_cmp++;
    if (rd16 !== 8'h01) begin n_err++; $display("FAIL ena_count got %02h exp 01", rd16); end
    rd(4'd8);
    n_cmp++;
    if (rd16 !== 8'h02) begin n_err++; $display("FAIL ena_width got %02h exp 02", rd16); end
    rd(4'd10);
    n_cmp++;
    if (rd16 !== 8'h05) begin n_err++; $display("FAIL ena_status got %02h exp 05", rd16); end
    hold(1'b1, 3); hold(1'b0, 4);
    rd(4'd0);
    n_cmp++;
    if (rd16 !== 8'h02) begin n_err++; $display("FAIL ena_next_count got %02h exp 02", rd16); end
    rd(4'd8);
    n_cmp++;
    if (rd16 !== 8'h03) begin n_err++; $display("FAIL ena_next_width got %02h exp 03", rd16); end
    // 15 cycles between rises, 4 of them disabled.
    rd(4'd2);
    n_cmp++;
    if (rd16 !== 8'h0B) begin n_err++; $display("FAIL ena_interval got %02h exp 0B", rd16); end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    cyc    = 0;
    iv_cnt = 0;
    iv_cyc[0] = 0;
    iv_cyc[1] = 0;
    test_reset();
    test_intervals();
    test_back_to_back();
    test_saturation();
    test_clear_collision();
    test_ena_gating();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
